proc_mem_responder: RTL and testbench
=====================================

// Module: proc_mem_responder
// PURPOSE
//  Memory-side responder for the processor's fetch/load/store bus. Single-ported
//  word memory: accepts one read or write request at a time, inserts WAIT_CYC
//  wait states, returns one response per request. Sits between the processor
//  core (initiator) and program/data storage. Side port preloads the program.
// PARAMETERS
//  DATA_W    32  data word width
//  ADDR_W    12  request address width (matches 12-bit instruction address fields)
//  DEPTH     64  implemented words; addresses >= DEPTH are out of range
//  WAIT_CYC  2   wait states between accept and access (0..15)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  init_en    in   1       preload write strobe (program/data loader)
//  init_addr  in   ADDR_W  preload address
//  init_data  in   DATA_W  preload data
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept request
//  req_we     in   1       1 = store, 0 = fetch/load
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  store data
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       initiator takes response
//  rsp_rdata  out  DATA_W  read data (0 for writes and errors)
//  rsp_err    out  1       request addressed out of range
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all memory words=0, req_ready=0 while
//   rst_n low, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: req_ready = ~init_en. Accept when req_valid & req_ready at an edge:
//   latch we/addr/wdata, load counter=WAIT_CYC, go WAIT.
//  WAIT: req_ready=0. Counter>0: decrement. Counter==0: perform access at that
//   edge, go RESP. Access: in range & we -> mem[addr]=wdata, rdata=0;
//   in range & ~we -> rdata=mem[addr]; out of range -> no write, rdata=0, err=1.
//  RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1 at an
//   edge, then rsp_valid=0, rsp_err=0, go IDLE. No request accepted same edge.
//  Latency: rsp_valid rises exactly WAIT_CYC+1 edges after accept edge.
//   Min request-to-request spacing WAIT_CYC+3 cycles with rsp_ready tied high.
//  Writes always produce a response (ack); initiator must consume it.
//  Preload: init_en & in-range init_addr writes mem at edge in any state except
//   same edge as a WAIT-state access to same address (access wins). Out-of-range
//   init_addr ignored. init_en high forces req_ready=0 in IDLE.
//  Read-after-write: read issued after write response sees new data.
//  Reset mid-operation: pending request discarded; write not yet reached its
//   access edge is not performed; response not delivered; memory cleared.
//  Address compare uses full ADDR_W bits; no wrap/aliasing.
// TESTING
//  1 WAIT_CYC=2: write addr 5 data 32'h50001001 -> ack rsp_valid 3 edges after
//    accept, rdata=0, err=0; read addr 5 -> rdata=32'h50001001.
//  2 WAIT_CYC=0 and 15: read latency 1 and 16 edges; req_ready low throughout.
//  3 Read addr 12'h040 (DEPTH=64) -> err=1, rdata=0; write 12'hFFF -> err=1,
//    memory unchanged (scan all 64 words).
//  4 Backpressure: rsp_ready low 10 cycles -> rsp_valid/rdata stable, new
//    req_valid not accepted; release -> IDLE, next request accepted.
//  5 Preload mem[0..5] with 3,4,32'h50000001,... via init_en; req_ready=0
//    during preload; subsequent reads return preloaded values.
//  6 Assert rst_n=0 during WAIT of write to addr 3 -> outputs reset
//    immediately, mem[3]=0 after reset, no rsp_valid.

Source files
------------

// File: rtl/proc_mem_responder.sv
// Memory-side responder for the processor fetch/load/store bus: single-ported word
// memory, one request at a time, WAIT_CYC wait states, one response per request.
module proc_mem_responder #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the range check sees the full address without wrap.
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              addr_in_range;
    logic              init_in_range;
    logic              acc_wr;

    assign addr_in_range = ({1'b0, addr_q} < DepthW);
    assign init_in_range = ({1'b0, init_addr} < DepthW);

    assign req_ready = (state_q == StIdle) && !init_en && rst_n;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        acc_wr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYC);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    if (!addr_in_range) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        acc_wr  = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q[IdxW-1:0]];
                        err_d   = 1'b0;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus access is assigned last so it wins over a same-edge preload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (init_en && init_in_range) begin
                mem_q[init_addr[IdxW-1:0]] <= init_data;
            end
            if (acc_wr) begin
                mem_q[addr_q[IdxW-1:0]] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Self-checking bench for proc_mem_responder: vector table, directed corner sequences
// and random traffic against an array model of the memory.
module tb_proc_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_en;
    logic [11:0] init_addr;
    logic [31:0] init_data;
    logic        req_valid;
    logic        req_valid_aux;
    logic        req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        rr0, rv0, re0, b0;
    logic [31:0] rd0;
    logic        rr15, rv15, re15, b15;
    logic [31:0] rd15;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [64];

    always #5 clk = ~clk;

    proc_mem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr),
        .init_data(init_data), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    proc_mem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYC(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr),
        .init_data(init_data), .req_valid(req_valid_aux), .req_ready(rr0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0),
        .rsp_err(re0), .busy(b0)
    );

    proc_mem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYC(15)) dut_w15 (
        .clk(clk), .rst_n(rst_n), .init_en(init_en), .init_addr(init_addr),
        .init_data(init_data), .req_valid(req_valid_aux), .req_ready(rr15),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv15), .rsp_ready(rsp_ready), .rsp_rdata(rd15),
        .rsp_err(re15), .busy(b15)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: what a request should return, given the model memory.
    function automatic logic [31:0] exp_rdata(input logic we, input logic [11:0] addr);
        if (we || addr >= 12'd64) return 32'h0;
        return model_mem[addr[5:0]];
    endfunction

    function automatic void model_apply(input logic we, input logic [11:0] addr,
                                        input logic [31:0] wd);
        if (we && addr < 12'd64) model_mem[addr[5:0]] = wd;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    endfunction

    // One transaction on the WAIT_CYC=2 instance with rsp_ready high.
    task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            rd = 32'h0; er = 1'b0; lat = -1;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t        vecs [10];
        logic [31:0] rd, held;
        logic        er;
        int          lat, lat0, lat15;
        logic        ready_bad;
        logic [31:0] pre [6];

        vecs[0] = '{1'b1, 12'h005, 32'h50001001, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 12'h005, 32'h0,        32'h50001001, 1'b0};
        vecs[2] = '{1'b0, 12'h040, 32'h0,        32'h0,        1'b1};
        vecs[3] = '{1'b1, 12'hFFF, 32'hDEADBEEF, 32'h0,        1'b1};
        vecs[4] = '{1'b1, 12'h03F, 32'hA5A50063, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 12'h03F, 32'h0,        32'hA5A50063, 1'b0};
        vecs[6] = '{1'b0, 12'h000, 32'h0,        32'h0,        1'b0};
        vecs[7] = '{1'b1, 12'h000, 32'h00001234, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 12'h000, 32'h0,        32'h00001234, 1'b0};
        vecs[9] = '{1'b1, 12'h805, 32'h11112222, 32'h0,        1'b1};

        rst_n = 1'b0; init_en = 1'b0; init_addr = '0; init_data = '0;
        req_valid = 1'b0; req_valid_aux = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'h1);

        // Latency at WAIT_CYC=0 and 15
        req_we = 1'b0; req_addr = 12'h001; req_valid_aux = 1'b1;
        @(posedge clk);
        #1 req_valid_aux = 1'b0;
        lat0 = 0; lat15 = 0; ready_bad = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (rv0 && lat0 == 0) lat0 = e;
            if (rv15 && lat15 == 0) lat15 = e;
            if (lat0 == 0 && rr0) ready_bad = 1'b1;
            if (lat15 == 0 && rr15) ready_bad = 1'b1;
        end
        check("lat_wait0", 32'(lat0), 32'd1);
        check("lat_wait15", 32'(lat15), 32'd16);
        check("aux_ready_low_while_waiting", 32'(ready_bad), 32'h0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        // Out-of-range writes must leave every word untouched
        for (int a = 0; a < 64; a++) begin
            do_req(1'b0, 12'(a), 32'h0, rd, er, lat);
            check($sformatf("scan_mem%0d", a), rd, model_mem[a]);
        end

        // Preload, including one ignored out-of-range word
        pre[0] = 32'h3; pre[1] = 32'h4; pre[2] = 32'h50000001;
        pre[3] = 32'h50000002; pre[4] = 32'h50000003; pre[5] = 32'h50000004;
        ready_bad = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            init_en = 1'b1;
            req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h00A; req_wdata = 32'hBAD0BAD0;
            init_addr = (i == 6) ? 12'h040 : 12'(i);
            init_data = (i == 6) ? 32'hFFFFFFFF : pre[i];
            #1;
            if (req_ready) ready_bad = 1'b1;
            if (i < 6) model_mem[i] = pre[i];
        end
        @(negedge clk);
        init_en = 1'b0; req_valid = 1'b0;
        check("preload_ready_low", 32'(ready_bad), 32'h0);
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, 12'(i), 32'h0, rd, er, lat);
            check($sformatf("preload_rd%0d", i), rd, pre[i]);
        end
        do_req(1'b0, 12'h00A, 32'h0, rd, er, lat);
        check("preload_no_accept", rd, model_mem[10]);
        do_req(1'b0, 12'h040, 32'h0, rd, er, lat);
        check("preload_oor_err", 32'(er), 32'h1);

        // Backpressure
        @(negedge clk);
        req_we = 1'b0; req_addr = 12'h005; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd3);
        held = rsp_rdata;
        check("bp_rdata", held, pre[5]);
        @(negedge clk);
        req_we = 1'b1; req_addr = 12'h009; req_wdata = 32'h99999999; req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", 32'(rsp_valid), 32'h1);
            check("bp_rdata_held", rsp_rdata, held);
            check("bp_req_ready_low", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(rsp_valid), 32'h0);
        check("bp_release_busy", 32'(busy), 32'h0);
        do_req(1'b0, 12'h009, 32'h0, rd, er, lat);
        check("bp_next_req", rd, model_mem[9]);
        check("bp_next_latency", 32'(lat), 32'd3);

        // Random traffic against the model
        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [11:0] addr;
            logic [31:0] wd, exp;
            logic        exp_err;
            we = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 69));
            wd = $urandom;
            exp = exp_rdata(we, addr);
            exp_err = (addr >= 12'd64);
            do_req(we, addr, wd, rd, er, lat);
            check($sformatf("rand%0d_rdata a=%h we=%0d", t, addr, we), rd, exp);
            check($sformatf("rand%0d_err", t), 32'(er), 32'(exp_err));
            check($sformatf("rand%0d_latency", t), 32'(lat), 32'd3);
            model_apply(we, addr, wd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the wait of a write
        @(negedge clk);
        req_we = 1'b1; req_addr = 12'h003; req_wdata = 32'hCAFE0003; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(rsp_valid), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        ready_bad = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid) ready_bad = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) ready_bad = 1'b1;
        end
        check("midrst_no_response", 32'(ready_bad), 32'h0);
        do_req(1'b0, 12'h003, 32'h0, rd, er, lat);
        check("midrst_mem3", rd, model_mem[3]);
        do_req(1'b0, 12'h005, 32'h0, rd, er, lat);
        check("midrst_mem5", rd, model_mem[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
